fp16_accumulator: RTL

//  Downstream neighbour of the FP16 multiplier stage in a systolic-array PE column.

---
 rtl/fp16_accumulator.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/fp16_accumulator.sv
// fp16_accumulator: sums each in_last-terminated packet of FP16 products with a
// single-cycle FP16 adder and presents the packet sum on a valid/ready port.
// Optional feature macro FP16_ACC_BIAS_EN adds a bias input that is added to
// the first beat of every packet.
module fp16_accumulator #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
`ifdef FP16_ACC_BIAS_EN
  input  logic [15:0]      bias,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  logic             first;
  logic [15:0]      acc;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      first_val;
  logic [15:0]      next_acc;
  logic [CNT_W-1:0] next_cnt;

  function automatic logic is_nan(input logic [15:0] v);
    return (v[14:10] == 5'h1f) && (v[9:0] != 10'd0);
  endfunction

  // FP16 add with guard/round/sticky alignment, round-to-nearest-even,
  // full subnormal support and canonical NaN output.
  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, r;
    logic [5:0]  ex, ey, d, e;
    logic [13:0] mx, my, shifted, my_al, n;
    logic [14:0] s;
    logic [15:0] pk;
    logic        sticky, round_up, a_inf, b_inf;
    a_inf = (a[14:10] == 5'h1f) && (a[9:0] == 10'd0);
    b_inf = (b[14:10] == 5'h1f) && (b[9:0] == 10'd0);
    r = 16'h0000;
    if (is_nan(a) || is_nan(b)) begin
      r = 16'h7E00;
    end else if (a_inf && b_inf) begin
      r = (a[15] == b[15]) ? a : 16'h7E00;
    end else if (a_inf) begin
      r = a;
    end else if (b_inf) begin
      r = b;
    end else begin
      // x carries the larger magnitude so the subtraction never goes negative
      if (a[14:0] >= b[14:0]) begin
        x = a;
        y = b;
      end else begin
        x = b;
        y = a;
      end
      ex = (x[14:10] == 5'd0) ? 6'd1 : {1'b0, x[14:10]};
      ey = (y[14:10] == 5'd0) ? 6'd1 : {1'b0, y[14:10]};
      mx = {(x[14:10] != 5'd0), x[9:0], 3'b000};
      my = {(y[14:10] != 5'd0), y[9:0], 3'b000};
      d  = ex - ey;
      if (d >= 6'd14) begin
        shifted = 14'd0;
        sticky  = |my;
      end else begin
        shifted = my >> d;
        sticky  = |(my & ((14'd1 << d) - 14'd1));
      end
      my_al = {shifted[13:1], shifted[0] | sticky};
      if (x[15] == y[15]) s = {1'b0, mx} + {1'b0, my_al};
      else                s = {1'b0, mx} - {1'b0, my_al};
      if (s == 15'd0) begin
        // exact zero is +0 unless both operands were -0
        r = (x[15] & y[15]) ? 16'h8000 : 16'h0000;
      end else begin
        e = ex;
        if (s[14]) begin
          n = {s[14:2], s[1] | s[0]};
          e = e + 6'd1;
        end else begin
          n = s[13:0];
          // normalise left but stop at the minimum exponent to produce subnormals
          for (int i = 0; i < 14; i++) begin
            if (!n[13] && (e > 6'd1)) begin
              n = n << 1;
              e = e - 6'd1;
            end
          end
        end
        round_up = n[2] & (n[1] | n[0] | n[3]);
        // rounding carry ripples from the fraction straight into the exponent
        pk = {(n[13] ? e : 6'd0), n[12:3]} + {15'd0, round_up};
        if (pk[15:10] >= 6'd31) r = {x[15], 5'h1f, 10'd0};
        else                    r = {x[15], pk[14:0]};
      end
    end
    return r;
  endfunction

  // value loaded into the accumulator on the first beat of a packet
  always_comb begin
`ifdef FP16_ACC_BIAS_EN
    first_val = fp16_add(bias, in_data);
`else
    first_val = is_nan(in_data) ? 16'h7E00 : in_data;
`endif
  end

  // next accumulator value and saturating beat count for an accepted beat
  always_comb begin
    next_acc = first ? first_val : fp16_add(acc, in_data);
    next_cnt = first ? {{(CNT_W-1){1'b0}}, 1'b1}
                     : ((cnt == CNT_MAX) ? cnt : cnt + {{(CNT_W-1){1'b0}}, 1'b1});
  end

  assign in_ready = (state == ACC);

  // packet FSM: accumulate beats in ACC, present the registered sum in HOLD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACC;
      first     <= 1'b1;
      acc       <= 16'h0000;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
      out_count <= '0;
    end else begin
      case (state)
        ACC: begin
          if (in_valid) begin
            acc   <= next_acc;
            cnt   <= next_cnt;
            first <= in_last;
            if (in_last) begin
              out_data  <= next_acc;
              out_count <= next_cnt;
              out_valid <= 1'b1;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule
